// File: rtl/frame_assembler.sv
// Packs an R,G,B byte stream into 24-bit pixel writes with linear frame-buffer addresses.
// Defining FRAME_ASSEMBLER_CHECKSUM_EN adds a per-frame 16-bit byte checksum on FrameSum.
module frame_assembler #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        FrameIn,
    input  logic              ByteValid,
    input  logic              SyncVB,
    output logic [23:0]       PixelData,
    output logic [ADDR_W-1:0] PixelAddr,
    output logic              PixelWE,
    output logic              LineDone,
    output logic              FrameDone,
    output logic              FrameErr,
    output logic [15:0]       FrameSum
);
    localparam int PIX_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(H_PIXELS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_LINES - 1);

    typedef enum logic [1:0] {WAIT_SYNC, GET_R, GET_G, GET_B} state_t;

    state_t              state_q, state_d;
    logic [7:0]          r_q, r_d, g_q, g_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [23:0]         data_q, data_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                we_q, we_d;
    logic                line_done_q, line_done_d;
    logic                frame_done_q, frame_done_d;
    logic                err_q, err_d;

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        g_d          = g_q;
        pix_d        = pix_q;
        line_d       = line_q;
        addr_d       = addr_q;
        data_d       = data_q;
        waddr_d      = waddr_q;
        we_d         = 1'b0;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;

        if (SyncVB) begin
            // A sync seen while capturing means the previous frame was cut short
            if (state_q != WAIT_SYNC) begin
                err_d = 1'b1;
            end
            state_d = GET_R;
            pix_d   = '0;
            line_d  = '0;
            addr_d  = '0;
        end else if (ByteValid && state_q != WAIT_SYNC) begin
            case (state_q)
                GET_R: begin
                    r_d     = FrameIn;
                    state_d = GET_G;
                end
                GET_G: begin
                    g_d     = FrameIn;
                    state_d = GET_B;
                end
                default: begin
                    data_d  = {r_q, g_q, FrameIn};
                    waddr_d = addr_q;
                    addr_d  = addr_q + ADDR_W'(1);
                    we_d    = 1'b1;
                    state_d = GET_R;
                    if (pix_q == LAST_PIX) begin
                        pix_d       = '0;
                        line_done_d = 1'b1;
                        if (line_q == LAST_LINE) begin
                            line_d       = '0;
                            frame_done_d = 1'b1;
                            state_d      = WAIT_SYNC;
                        end else begin
                            line_d = line_q + LINE_W'(1);
                        end
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_SYNC;
            r_q          <= '0;
            g_q          <= '0;
            pix_q        <= '0;
            line_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            waddr_q      <= '0;
            we_q         <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            g_q          <= g_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            waddr_q      <= waddr_d;
            we_q         <= we_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign PixelData = data_q;
    assign PixelAddr = waddr_q;
    assign PixelWE   = we_q;
    assign LineDone  = line_done_q;
    assign FrameDone = frame_done_q;
    assign FrameErr  = err_q;

`ifdef FRAME_ASSEMBLER_CHECKSUM_EN
    logic        accept;
    logic [15:0] sum_q, sum_d, fsum_q, fsum_d;

    assign accept = ByteValid && !SyncVB && (state_q != WAIT_SYNC);

    // The published sum includes the final byte, which is being accepted this same cycle
    always_comb begin
        sum_d  = sum_q;
        fsum_d = fsum_q;
        if (SyncVB) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + {8'h00, FrameIn};
        end
        if (frame_done_d) begin
            fsum_d = sum_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q  <= '0;
            fsum_q <= '0;
        end else begin
            sum_q  <= sum_d;
            fsum_q <= fsum_d;
        end
    end

    assign FrameSum = fsum_q;
`else
    assign FrameSum = '0;
`endif

endmodule

// File: tb/tb_frame_assembler.sv
// Self-checking bench for frame_assembler: byte-queue reference model, per-cycle compare,
// directed literal checks and randomized traffic.
module tb_frame_assembler;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 20;
`ifdef FRAME_ASSEMBLER_CHECKSUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    FrameIn = 8'h00;
    logic          ByteValid = 1'b0;
    logic          SyncVB = 1'b0;
    logic [23:0]   PixelData;
    logic [AW-1:0] PixelAddr;
    logic          PixelWE;
    logic          LineDone;
    logic          FrameDone;
    logic          FrameErr;
    logic [15:0]   FrameSum;

    int n_cmp  = 0;
    int n_fail = 0;

    frame_assembler #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .FrameIn   (FrameIn),
        .ByteValid (ByteValid),
        .SyncVB    (SyncVB),
        .PixelData (PixelData),
        .PixelAddr (PixelAddr),
        .PixelWE   (PixelWE),
        .LineDone  (LineDone),
        .FrameDone (FrameDone),
        .FrameErr  (FrameErr),
        .FrameSum  (FrameSum)
    );

    always #5 clk = ~clk;

    // Reference model: frame activity flag, partial-pixel byte list and write index
    bit            active;
    logic [7:0]    pb[3];
    int            nb;
    int            widx;
    bit            m_err;
    bit            m_we, m_ld, m_fd;
    logic [23:0]   m_data;
    logic [AW-1:0] m_addr;
    logic [15:0]   run_sum, m_sum;

    task automatic model_clear();
        active = 1'b0;
        nb = 0;
        widx = 0;
        m_err = 1'b0;
        m_we = 1'b0;
        m_ld = 1'b0;
        m_fd = 1'b0;
        m_data = '0;
        m_addr = '0;
        run_sum = '0;
        m_sum = '0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear();
        end else begin
            m_we = 1'b0;
            m_ld = 1'b0;
            m_fd = 1'b0;
            if (SyncVB) begin
                if (active) m_err = 1'b1;
                active = 1'b1;
                nb = 0;
                widx = 0;
                run_sum = '0;
            end else if (active && ByteValid) begin
                pb[nb] = FrameIn;
                nb++;
                run_sum = run_sum + 16'(FrameIn);
                if (nb == 3) begin
                    m_we   = 1'b1;
                    m_data = {pb[0], pb[1], pb[2]};
                    m_addr = AW'(widx);
                    m_ld   = (widx % H) == H - 1;
                    m_fd   = widx == H * V - 1;
                    if (m_fd) begin
                        active = 1'b0;
                        m_sum  = SUM_EN ? run_sum : 16'h0;
                    end
                    widx++;
                    nb = 0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("we",    32'(PixelWE),   32'(m_we));
        check_output("ld",    32'(LineDone),  32'(m_ld));
        check_output("fd",    32'(FrameDone), 32'(m_fd));
        check_output("err",   32'(FrameErr),  32'(m_err));
        check_output("data",  32'(PixelData), 32'(m_data));
        check_output("addr",  32'(PixelAddr), 32'(m_addr));
        check_output("sum",   32'(FrameSum),  32'(m_sum));
    end

    // Called at a negedge; returns at the negedge after the DUT has sampled the inputs
    task automatic apply_stimulus(input logic [7:0] b, input logic v, input logic s);
        #1;
        FrameIn   = b;
        ByteValid = v;
        SyncVB    = s;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_we"},   32'(PixelWE),   32'h0);
        check_output({tag, "_data"}, 32'(PixelData), 32'h0);
        check_output({tag, "_addr"}, 32'(PixelAddr), 32'h0);
        check_output({tag, "_ld"},   32'(LineDone),  32'h0);
        check_output({tag, "_fd"},   32'(FrameDone), 32'h0);
        check_output({tag, "_err"},  32'(FrameErr),  32'h0);
        check_output({tag, "_sum"},  32'(FrameSum),  32'h0);
    endtask

    task automatic do_reset();
        #1;
        reset     = 1'b0;
        ByteValid = 1'b0;
        SyncVB    = 1'b0;
        #1;
        check_all_zero("rst");
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int writes;
        int fds;
        reset = 1'b0;
        @(negedge clk);
        do_reset();

        // Three back-to-back bytes form the first pixel at address 0
        apply_stimulus(8'h00, 1'b0, 1'b1);
        apply_stimulus(8'h11, 1'b1, 1'b0);
        check_output("p1_we_gap", 32'(PixelWE), 32'h0);
        apply_stimulus(8'h22, 1'b1, 1'b0);
        apply_stimulus(8'h33, 1'b1, 1'b0);
        check_output("p1_we",   32'(PixelWE),   32'h1);
        check_output("p1_data", 32'(PixelData), 32'h112233);
        check_output("p1_addr", 32'(PixelAddr), 32'h0);

        // Full frame of 24 contiguous bytes
        do_reset();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        writes = 0;
        fds = 0;
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(8'(i + 1), 1'b1, 1'b0);
            if (PixelWE) begin
                check_output("full_addr", 32'(PixelAddr), 32'(writes));
                writes++;
                check_output("full_ld", 32'(LineDone), 32'((writes == 4) || (writes == 8)));
                if (FrameDone) begin
                    fds++;
                    check_output("full_fd_addr", 32'(PixelAddr), 32'h7);
                end
            end
        end
        check_output("full_writes", 32'(writes), 32'h8);
        check_output("full_fds", 32'(fds), 32'h1);
        for (int i = 0; i < 3; i++) apply_stimulus(8'h5A, 1'b1, 1'b0);
        check_output("full_idle_we", 32'(PixelWE), 32'h0);

        // Gapped ByteValid
        do_reset();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        apply_stimulus(8'hAA, 1'b1, 1'b0);
        apply_stimulus(8'hEE, 1'b0, 1'b0);
        check_output("gap_we1", 32'(PixelWE), 32'h0);
        apply_stimulus(8'hBB, 1'b1, 1'b0);
        apply_stimulus(8'hEE, 1'b0, 1'b0);
        check_output("gap_we2", 32'(PixelWE), 32'h0);
        apply_stimulus(8'hCC, 1'b1, 1'b0);
        check_output("gap_we",   32'(PixelWE),   32'h1);
        check_output("gap_data", 32'(PixelData), 32'hAABBCC);

        // Early sync after five bytes
        do_reset();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) apply_stimulus(8'(i), 1'b1, 1'b0);
        apply_stimulus(8'h77, 1'b1, 1'b1);
        check_output("early_we",  32'(PixelWE),  32'h0);
        check_output("early_err", 32'(FrameErr), 32'h1);
        apply_stimulus(8'h21, 1'b1, 1'b0);
        apply_stimulus(8'h22, 1'b1, 1'b0);
        apply_stimulus(8'h23, 1'b1, 1'b0);
        check_output("early_addr", 32'(PixelAddr), 32'h0);
        check_output("early_data", 32'(PixelData), 32'h212223);

        // Reset mid-frame, then bytes without sync
        do_reset();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) apply_stimulus(8'(i + 8'h40), 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(8'h99, 1'b1, 1'b0);
            check_output("mid_rst_we", 32'(PixelWE), 32'h0);
        end
        apply_stimulus(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) apply_stimulus(8'h31, 1'b1, 1'b0);
        check_output("mid_rst_we2",  32'(PixelWE),   32'h1);
        check_output("mid_rst_addr", 32'(PixelAddr), 32'h0);

        // Checksum of 24 bytes of 0x10, then sync while FrameDone is high
        do_reset();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) apply_stimulus(8'h10, 1'b1, 1'b0);
        check_output("sum_fd",  32'(FrameDone), 32'h1);
        check_output("sum_val", 32'(FrameSum),  SUM_EN ? 32'h0180 : 32'h0);
        apply_stimulus(8'h00, 1'b0, 1'b1);
        check_output("resync_err", 32'(FrameErr), 32'h0);
        for (int i = 0; i < 3; i++) apply_stimulus(8'h10, 1'b1, 1'b0);
        check_output("resync_we",   32'(PixelWE),   32'h1);
        check_output("resync_addr", 32'(PixelAddr), 32'h0);

        // Randomized traffic, checked every cycle by the model compare
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                apply_stimulus(8'($urandom), $urandom_range(0, 9) < 7,
                               $urandom_range(0, 59) == 0);
            end
        end
        apply_stimulus(8'h00, 1'b0, 1'b0);
        apply_stimulus(8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
